// File: rtl/terminal_reg_bank.sv
// Response queue: a small circular buffer of {addr, data} entries with an occupancy count.
// Latency: a pushed entry is visible at the head one edge later; push and pop may share an edge.
// Backpressure: the caller must not push when full or pop when empty; the full and empty flags report this.
module terminal_reg_bank_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // The extra pointer bit separates full from empty; pointers wrap modulo 2*DEPTH.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (wr_ptr == rd_ptr);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue so stale entries are never emitted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// Terminal-facing register bank: 16 x 32 registers (ID, 14 r/w, status) with queued read responses.
// Latency: writes take effect on the sampling edge; a read into an idle, empty path raises RSP_TR one edge later.
// Backpressure: responses wait for RSP_BUSY low; reads arriving with the queue full are dropped and flagged.
module terminal_reg_bank #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ID_VALUE = 32'h5350_4901
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CMD_VALID,
    input  logic [15:0] CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    output logic        RSP_TR,
    output logic [15:0] RSP_ADDR,
    output logic [31:0] RSP_DATA,
    input  logic        RSP_BUSY,
    output logic [31:0] REG1_OUT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] BAD_READ_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } rsp_state_t;

    logic [31:0] regs [1:14];
    logic [7:0]  err_cnt;
    logic        ovf;
    rsp_state_t  state;

    logic [3:0]  cmd_idx;
    logic        cmd_rd;
    logic        cmd_wr;
    logic        cmd_bad;
    logic        rd_drop;
    logic        err_inc;
    logic        err_clr;
    logic        reg_wr;
    logic [31:0] rd_val;
    logic [31:0] status_word;
    logic [2:0]  level3;

    logic        fifo_push;
    logic [47:0] fifo_push_dat;
    logic        fifo_pop;
    logic [47:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;

    // Command decode: bit 15 selects read, any of bits 14:4 set marks the command invalid.
    assign cmd_idx = CMD_ADDR[3:0];
    assign cmd_bad = |CMD_ADDR[14:4];
    assign cmd_rd  = CMD_VALID &&  CMD_ADDR[15];
    assign cmd_wr  = CMD_VALID && !CMD_ADDR[15];
    assign reg_wr  = cmd_wr && !cmd_bad && (cmd_idx != 4'd0) && (cmd_idx != 4'd15);
    assign err_clr = cmd_wr && !cmd_bad && (cmd_idx == 4'd15) && CMD_DATA[0];

    // A read that finds the queue full is lost; an invalid one still counts as a single error.
    assign rd_drop = cmd_rd && fifo_full;
    assign err_inc = CMD_VALID && (cmd_bad || rd_drop);

    assign level3      = 3'(fifo_level);
    assign status_word = {16'h0000, err_cnt, 4'h0, ovf, level3};
    assign REG1_OUT    = regs[1];

    // Read mux returns pre-edge contents, so a read of the status sees the level before its own push.
    always_comb begin
        rd_val = 32'h0000_0000;
        if (cmd_idx == 4'd0) begin
            rd_val = ID_VALUE;
        end else if (cmd_idx == 4'd15) begin
            rd_val = status_word;
        end else begin
            for (int i = 1; i <= 14; i++) begin
                if (cmd_idx == 4'(i)) rd_val = regs[i];
            end
        end
    end

    assign fifo_push     = cmd_rd && !fifo_full;
    assign fifo_push_dat = {CMD_ADDR, (cmd_bad ? BAD_READ_DATA : rd_val)};
    assign fifo_pop      = (state == IDLE) && !fifo_empty && !RSP_BUSY;

    terminal_reg_bank_fifo #(
        .WIDTH (48),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Read/write register file: indices 1..14 take valid writes on the sampling edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 1; i <= 14; i++) regs[i] <= 32'h0000_0000;
        end else if (reg_wr) begin
            for (int i = 1; i <= 14; i++) begin
                if (cmd_idx == 4'(i)) regs[i] <= CMD_DATA;
            end
        end
    end

    // Error counter saturates at 255; overflow is sticky until cleared through the status register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt <= 8'd0;
            ovf     <= 1'b0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
            ovf     <= 1'b0;
        end else begin
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (rd_drop)                       ovf     <= 1'b1;
        end
    end

    // Response handshake: pop into the held address/data, raise TR until BUSY is seen, then wait for BUSY to drop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            RSP_TR   <= 1'b0;
            RSP_ADDR <= 16'h0000;
            RSP_DATA <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        RSP_ADDR <= fifo_head[47:32];
                        RSP_DATA <= fifo_head[31:0];
                        RSP_TR   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (RSP_BUSY) begin
                        RSP_TR <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!RSP_BUSY) state <= IDLE;
                end
                default: begin
                    RSP_TR <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_terminal_reg_bank.sv
// Directed bench for terminal_reg_bank with a scoreboard of expected responses.
// A Terminal model answers each RSP_TR with a short BUSY pulse unless disabled or overridden.
// A monitor pops the scoreboard on every RSP_TR rising edge and compares address and data.
module tb_terminal_reg_bank;

    logic        CLK;
    logic        RESET_N;
    logic        CMD_VALID;
    logic [15:0] CMD_ADDR;
    logic [31:0] CMD_DATA;
    logic        RSP_TR;
    logic [15:0] RSP_ADDR;
    logic [31:0] RSP_DATA;
    logic        RSP_BUSY;
    logic [31:0] REG1_OUT;

    logic        force_busy;
    logic        term_busy;
    logic        auto_en;

    logic [47:0] sb[$];
    int          checks;
    int          failures;

    assign RSP_BUSY = force_busy | term_busy;

    terminal_reg_bank #(
        .DEPTH    (4),
        .ID_VALUE (32'h5350_4901)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CMD_VALID (CMD_VALID),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .RSP_TR    (RSP_TR),
        .RSP_ADDR  (RSP_ADDR),
        .RSP_DATA  (RSP_DATA),
        .RSP_BUSY  (RSP_BUSY),
        .REG1_OUT  (REG1_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [15:0] a, input logic [31:0] d);
        CMD_VALID = 1'b1;
        CMD_ADDR  = a;
        CMD_DATA  = d;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic expect_rsp(input logic [15:0] a, input logic [31:0] d);
        sb.push_back({a, d});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 48'(sb.size()), 48'd0);
        repeat (6) @(negedge CLK);
    endtask

    // Terminal model: acknowledge each request with BUSY for two cycles.
    initial begin
        term_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RSP_TR && auto_en && RESET_N) begin
                term_busy = 1'b1;
                repeat (2) @(negedge CLK);
                term_busy = 1'b0;
            end
        end
    end

    // Monitor: every new request must match the oldest expected response.
    initial begin
        logic prev_tr;
        logic [47:0] exp;
        prev_tr = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                prev_tr = 1'b0;
            end else begin
                if (RSP_TR && !prev_tr) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=%h required=none", {RSP_ADDR, RSP_DATA});
                    end else begin
                        exp = sb.pop_front();
                        chk("rsp", {RSP_ADDR, RSP_DATA}, exp);
                    end
                end
                prev_tr = RSP_TR;
            end
        end
    end

    initial begin
        logic seen;
        checks     = 0;
        failures   = 0;
        RESET_N    = 1'b0;
        CMD_VALID  = 1'b0;
        CMD_ADDR   = 16'h0000;
        CMD_DATA   = 32'h0000_0000;
        force_busy = 1'b0;
        auto_en    = 1'b1;

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_tr",   48'(RSP_TR),   48'd0);
        chk("rst_addr", 48'(RSP_ADDR), 48'd0);
        chk("rst_data", 48'(RSP_DATA), 48'd0);
        chk("rst_reg1", 48'(REG1_OUT), 48'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Write then read back, with first-response latency
        cmd(16'h0003, 32'h1234_5678);
        expect_rsp(16'h8003, 32'h1234_5678);
        cmd(16'h8003, 32'h0);
        chk("tr_not_yet", 48'(RSP_TR), 48'd0);
        @(negedge CLK);
        chk("latency_tr", 48'(RSP_TR), 48'd1);
        wait_drain("drain_basic");

        // ID register and REG1 output
        expect_rsp(16'h8000, 32'h5350_4901);
        cmd(16'h8000, 32'h0);
        cmd(16'h0001, 32'hA5A5_0001);
        chk("reg1_out", 48'(REG1_OUT), 48'hA5A5_0001);
        cmd(16'h000E, 32'hCAFE_0014);
        expect_rsp(16'h8001, 32'hA5A5_0001);
        cmd(16'h8001, 32'h0);
        expect_rsp(16'h800E, 32'hCAFE_0014);
        cmd(16'h800E, 32'h0);
        wait_drain("drain_id");

        // Invalid write and read, status, clear
        cmd(16'h0013, 32'hFFFF_FFFF);
        expect_rsp(16'h8013, 32'hDEAD_BEEF);
        cmd(16'h8013, 32'h0);
        wait_drain("drain_bad");
        expect_rsp(16'h800F, 32'h0000_0200);
        cmd(16'h800F, 32'h0);
        expect_rsp(16'h8003, 32'h1234_5678);
        cmd(16'h8003, 32'h0);
        wait_drain("drain_stat1");
        cmd(16'h000F, 32'h0000_0001);
        cmd(16'h0000, 32'hFFFF_FFFF);
        expect_rsp(16'h800F, 32'h0000_0000);
        cmd(16'h800F, 32'h0);
        expect_rsp(16'h8000, 32'h5350_4901);
        cmd(16'h8000, 32'h0);
        wait_drain("drain_clear");

        // Status level sampled with one entry queued
        expect_rsp(16'h8002, 32'h0000_0000);
        cmd(16'h8002, 32'h0);
        expect_rsp(16'h800F, 32'h0000_0001);
        cmd(16'h800F, 32'h0);
        wait_drain("drain_level");

        // Overflow: six reads against a stalled Terminal
        force_busy = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_rsp(16'h8001, 32'hA5A5_0001);
            cmd(16'h8001, 32'h0);
        end
        repeat (3) @(negedge CLK);
        chk("stalled_tr", 48'(RSP_TR), 48'd0);
        force_busy = 1'b0;
        wait_drain("drain_ovf");
        expect_rsp(16'h800F, 32'h0000_0208);
        cmd(16'h800F, 32'h0);
        wait_drain("drain_ovf_stat");
        cmd(16'h000F, 32'h0000_0001);

        // Error counter saturation
        for (int i = 0; i < 260; i++) cmd(16'h0010, 32'h0);
        expect_rsp(16'h800F, 32'h0000_FF00);
        cmd(16'h800F, 32'h0);
        wait_drain("drain_sat");
        cmd(16'h000F, 32'h0000_0001);
        repeat (2) @(negedge CLK);

        // Reset during a pending request with two entries queued
        auto_en = 1'b0;
        expect_rsp(16'h8001, 32'hA5A5_0001);
        cmd(16'h8001, 32'h0);
        expect_rsp(16'h8002, 32'h0000_0000);
        cmd(16'h8002, 32'h0);
        expect_rsp(16'h8003, 32'h1234_5678);
        cmd(16'h8003, 32'h0);
        chk("req_held", 48'(RSP_TR), 48'd1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_tr",   48'(RSP_TR),   48'd0);
        chk("mid_rst_data", 48'(RSP_DATA), 48'd0);
        chk("mid_rst_reg1", 48'(REG1_OUT), 48'd0);
        sb.delete();
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        auto_en = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (RSP_TR) seen = 1'b1;
        end
        chk("quiet_after_rst", 48'(seen), 48'd0);
        expect_rsp(16'h8003, 32'h0000_0000);
        cmd(16'h8003, 32'h0);
        expect_rsp(16'h800F, 32'h0000_0001);
        cmd(16'h800F, 32'h0);
        wait_drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
